// File: rtl/spi_pkg.sv
// spi_pkg: FSM states, frame lengths and command encodings shared by the SPI frame master
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
    localparam int WR_BITS = 81;
    localparam int RD_BITS = 25;
    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ = 1'b1;
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCLK half-period timer, ticks at the end of each low and high half while enabled
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic rise_tick_o,
    output logic fall_tick_o
);
    import spi_pkg::*;
    localparam int CW = cnt_w(CLK_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          wrap;
    always_comb begin
        wrap = en_i && cnt_q == CW'(CLK_DIV - 1);
        cnt_d = (!en_i || wrap) ? '0 : cnt_q + CW'(1);
        phase_d = en_i && (wrap ? !phase_q : phase_q);
        rise_tick_o = wrap && !phase_q;
        fall_tick_o = wrap && phase_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            phase_q <= phase_d;
        end
    end
endmodule

// File: rtl/spi_frame_master.sv
// spi_frame_master: serialises one latched APB transaction as a mode-0 SPI frame, returning one read byte.
// Define SPI_LSB_FIRST_EN to shift address, write data and read byte LSB first.
module spi_frame_master #(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int RD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              r_w,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic [RD_W-1:0]   rd_data,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    import spi_pkg::*;
    localparam int SR_W = 1 + ADDR_W + DATA_W;
    localparam int RD_N = 1 + ADDR_W + RD_W;
    localparam int BC_W = $clog2((SR_W > RD_N ? SR_W : RD_N) + 1);
    localparam int CW = cnt_w(CLK_DIV);
    state_t            state_q;
    logic [SR_W-1:0]   sr_q, load;
    logic [BC_W-1:0]   bit_q;
    logic [CW-1:0]     wait_q;
    logic [RD_W-1:0]   rx_q, rx_nxt, rd_q;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] data_o;
    logic              cmd_q, busy_q, done_q, sclk_q, cs_n_q, mosi_q;
    logic              rise, fall, last_bit, wait_end;
    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk(clk),
        .reset(reset),
        .en_i(state_q == SHIFT),
        .rise_tick_o(rise),
        .fall_tick_o(fall)
    );
    // Reads pad the payload slot with zeros so MOSI stays low while MISO is captured
    always_comb begin
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < ADDR_W; i++) addr_o[i] = in_addr[ADDR_W-1-i];
        for (int i = 0; i < DATA_W; i++) data_o[i] = in_data[DATA_W-1-i];
        rx_nxt = {spi_miso, rx_q[RD_W-1:1]};
`else
        addr_o = in_addr;
        data_o = in_data;
        rx_nxt = {rx_q[RD_W-2:0], spi_miso};
`endif
        load = {r_w, addr_o, r_w == CMD_WRITE ? data_o : '0};
        last_bit = bit_q == BC_W'(cmd_q == CMD_READ ? RD_N - 1 : SR_W - 1);
        wait_end = wait_q == CW'(CLK_DIV - 1);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q <= '0;
            bit_q <= '0;
            wait_q <= '0;
            rx_q <= '0;
            rd_q <= '0;
            cmd_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sclk_q <= 1'b0;
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    sr_q <= load;
                    cmd_q <= r_w;
                    busy_q <= 1'b1;
                    cs_n_q <= 1'b0;
                    mosi_q <= r_w;
                    bit_q <= '0;
                    wait_q <= '0;
                    state_q <= SETUP;
                end
                SETUP: begin
                    wait_q <= wait_end ? '0 : wait_q + CW'(1);
                    if (wait_end) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (rise) begin
                        sclk_q <= 1'b1;
                        rx_q <= rx_nxt;
                    end
                    if (fall) begin
                        sclk_q <= 1'b0;
                        sr_q <= sr_q << 1;
                        mosi_q <= sr_q[SR_W-2];
                        bit_q <= bit_q + BC_W'(1);
                        if (last_bit) state_q <= HOLD;
                    end
                end
                HOLD: begin
                    wait_q <= wait_end ? '0 : wait_q + CW'(1);
                    if (wait_end) begin
                        state_q <= DONE;
                        done_q <= 1'b1;
                        cs_n_q <= 1'b1;
                        mosi_q <= 1'b0;
                        if (cmd_q == CMD_READ) rd_q <= rx_q;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign rd_data = rd_q;
    assign spi_sclk = sclk_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: vector table and corner sequences on a CLK_DIV=2 instance (0) and a CLK_DIV=1 instance (1)
module tb_spi_frame_master;
    import spi_pkg::*;
    typedef struct {
        int          d;
        logic        rw;
        logic [15:0] addr;
        logic [63:0] data;
        logic [7:0]  sb;
        int          exp_done;
        int          exp_rises;
        logic [7:0]  exp_rd;
    } vec_t;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   start_v = '0;
    logic [1:0]   rw_v = '0;
    logic [1:0]   busy_v, done_v, sclk_v, cs_v, mosi_v;
    logic [1:0]   miso_v;
    logic [15:0]  addr_a[2];
    logic [63:0]  data_a[2];
    logic [7:0]   rd_a[2];
    logic [7:0]   sbyte[2];
    int           rises[2];
    logic [127:0] cap[2];
    logic [1:0]   sclk_p = '0;
    logic [1:0]   cs_p = '1;
    int           errors = 0;
    int           checks = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_frame_master #(.CLK_DIV(g == 0 ? 2 : 1)) dut (
            .clk(clk), .reset(reset), .start(start_v[g]), .r_w(rw_v[g]),
            .in_addr(addr_a[g]), .in_data(data_a[g]), .busy(busy_v[g]), .done(done_v[g]),
            .rd_data(rd_a[g]), .spi_sclk(sclk_v[g]), .spi_cs_n(cs_v[g]),
            .spi_mosi(mosi_v[g]), .spi_miso(miso_v[g]));
    end
    // Slave monitor: counts SCLK rises, records MOSI while SCLK is high, restarts at CS fall
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs_p[i] && !cs_v[i]) begin
                rises[i] = 0;
                cap[i] = '0;
            end else if (sclk_v[i] && !sclk_p[i]) begin
                cap[i] = {cap[i][126:0], mosi_v[i]};
                rises[i]++;
            end
        end
        sclk_p = sclk_v;
        cs_p = cs_v;
    end
    // Slave drives the response byte during the last 8 bit slots of a read frame
    always_comb begin
        miso_v = '0;
        for (int i = 0; i < 2; i++)
            if (rises[i] >= 17 && rises[i] < 25)
`ifdef SPI_LSB_FIRST_EN
                miso_v[i] = sbyte[i][3'(rises[i] - 17)];
`else
                miso_v[i] = sbyte[i][3'(24 - rises[i])];
`endif
    end
    function automatic logic [127:0] exp_stream(input logic rw, input logic [15:0] a, input logic [63:0] d);
        logic [15:0] ao;
        logic [63:0] dd;
        ao = a;
        dd = d;
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < 16; i++) ao[i] = a[15-i];
        for (int i = 0; i < 64; i++) dd[i] = d[63-i];
`endif
        return rw ? 128'({rw, ao, 8'h00}) : 128'({rw, ao, dd});
    endfunction
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Starts a frame, scrambles inputs after capture, optionally pulses start again at cycle glitch,
    // returns the cycle index (1 = first cycle after the accepting edge) at which done is seen, 0 on timeout
    task automatic run_frame(input int d, input logic rw, input logic [15:0] a, input logic [63:0] dat,
                             input logic [7:0] sb, input int glitch, output int dc);
        sbyte[d] = sb;
        @(negedge clk);
        chk($sformatf("dut%0d idle before start", d), busy_v[d], 1'b0);
        start_v[d] = 1'b1;
        rw_v[d] = rw;
        addr_a[d] = a;
        data_a[d] = dat;
        @(posedge clk);
        dc = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (c == 1) begin
                rw_v[d] = ~rw;
                addr_a[d] = ~a;
                data_a[d] = ~dat;
                chk($sformatf("dut%0d busy after accept", d), busy_v[d], 1'b1);
            end
            start_v[d] = (c == glitch);
            if (done_v[d]) begin
                dc = c;
                break;
            end
        end
        start_v[d] = 1'b0;
    endtask
    initial begin
        vec_t v[8];
        int   dc;
        int   nb;
        int   seen;
        logic lsb_bit;
        v[0] = '{0, 1'b0, 16'h1234, 64'hDEADBEEF_CAFEF00D, 8'h00, 329, 81, 8'h00};
        v[1] = '{0, 1'b1, 16'hAAAB, 64'h0, 8'hA5, 105, 25, 8'hA5};
        v[2] = '{0, 1'b0, 16'hFFFF, 64'h0, 8'h00, 329, 81, 8'hA5};
        v[3] = '{0, 1'b1, 16'h0001, 64'h0, 8'h01, 105, 25, 8'h01};
        v[4] = '{1, 1'b1, 16'h5A5A, 64'h0, 8'h3C, 53, 25, 8'h3C};
        v[5] = '{1, 1'b0, 16'h8001, 64'h01234567_89ABCDEF, 8'h00, 165, 81, 8'h3C};
        v[6] = '{1, 1'b1, 16'h0000, 64'h0, 8'hFF, 53, 25, 8'hFF};
        v[7] = '{0, 1'b1, 16'hFFFF, 64'h0, 8'h80, 105, 25, 8'h80};
`ifdef SPI_LSB_FIRST_EN
        lsb_bit = 1'b1;
`else
        lsb_bit = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            addr_a[i] = '0;
            data_a[i] = '0;
            sbyte[i] = '0;
            cap[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset cs_n", cs_v, 2'b11);
        chk("reset sclk", sclk_v, 2'b00);
        chk("reset mosi", mosi_v, 2'b00);
        chk("reset busy", busy_v, 2'b00);
        chk("reset done", done_v, 2'b00);
        chk("reset rd_data", {rd_a[1], rd_a[0]}, 16'h0000);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_frame(v[i].d, v[i].rw, v[i].addr, v[i].data, v[i].sb, 0, dc);
            nb = v[i].rw ? RD_BITS : WR_BITS;
            chk($sformatf("v%0d done cycle", i), dc, v[i].exp_done);
            chk($sformatf("v%0d sclk rises", i), rises[v[i].d], v[i].exp_rises);
            chk($sformatf("v%0d mosi stream", i), cap[v[i].d] & ((128'(1) << nb) - 128'(1)),
                exp_stream(v[i].rw, v[i].addr, v[i].data));
            chk($sformatf("v%0d rd_data", i), rd_a[v[i].d], v[i].exp_rd);
            chk($sformatf("v%0d cs_n at done", i), cs_v[v[i].d], 1'b1);
            if (i == 3) chk("addr lsb after cmd bit", cap[0][23], lsb_bit);
        end
        // Start pulsed mid-frame and in the DONE cycle must both be ignored
        run_frame(0, 1'b1, 16'h0F0F, 64'h0, 8'h5C, 20, dc);
        chk("glitch frame done cycle", dc, 105);
        chk("glitch frame rises", rises[0], 25);
        chk("glitch frame rd_data", rd_a[0], 8'h5C);
        start_v[0] = 1'b1;
        rw_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("start in done ignored busy", busy_v[0], 1'b0);
        chk("cs_n high after done", cs_v[0], 1'b1);
        repeat (4) @(negedge clk);
        chk("still idle busy", busy_v[0], 1'b0);
        chk("still idle cs_n", cs_v[0], 1'b1);
        run_frame(0, 1'b0, 16'h00FF, 64'h1, 8'h00, 0, dc);
        chk("clean frame done cycle", dc, 329);
        chk("clean frame rises", rises[0], 81);
        chk("clean frame stream", cap[0] & ((128'(1) << WR_BITS) - 128'(1)), exp_stream(1'b0, 16'h00FF, 64'h1));
        chk("write keeps rd_data", rd_a[0], 8'h5C);
        // Mid-frame reset aborts at once, clears rd_data and produces no done
        @(negedge clk);
        start_v[0] = 1'b1;
        rw_v[0] = 1'b0;
        addr_a[0] = 16'hFFFF;
        data_a[0] = '1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid-frame cs_n low", cs_v[0], 1'b0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort%0d cs_n", c), cs_v[0], 1'b1);
            chk($sformatf("abort%0d sclk", c), sclk_v[0], 1'b0);
            chk($sformatf("abort%0d mosi", c), mosi_v[0], 1'b0);
            chk($sformatf("abort%0d busy", c), busy_v[0], 1'b0);
            chk($sformatf("abort%0d done", c), done_v[0], 1'b0);
            chk($sformatf("abort%0d rd_data", c), rd_a[0], 8'h00);
        end
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) seen++;
        end
        chk("no done or busy after abort", seen, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
